control_escritura: RTL

CONTROL_ESCRITURA -- requirements
Module: control_escritura

---
 rtl/imagen_pkg.sv | 13 +
 rtl/skid_buffer_8.sv | 53 +++++
 rtl/control_escritura.sv | 130 +++++++++++++
 3 files changed

// File: rtl/imagen_pkg.sv
// Shared FSM encoding and default frame geometry for the frame-buffer writer.
package imagen_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [18:0] DEF_BASE_ADDR = 19'h28;
  localparam int DEF_IMG_W  = 64;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_STRIDE = 64;
endpackage

// File: rtl/skid_buffer_8.sv
// One-entry skid buffer for an 8-bit stream; SKID=0 makes it a plain
// combinational pass-through.
module skid_buffer_8 #(
  parameter bit SKID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  if (SKID) begin : g_skid
    logic       full;
    logic       full_nxt;
    logic       rdy;
    logic       push;
    logic [7:0] hold;

    // Upstream ready comes only from flops, never from out_ready.
    assign in_ready  = rdy & en;
    assign push      = in_valid & in_ready & ~out_ready;
    assign out_valid = full | (in_valid & in_ready);
    assign out_data  = full ? hold : in_data;

    always_comb begin
      full_nxt = full;
      if (full && out_ready) full_nxt = 1'b0;
      else if (push)         full_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full <= 1'b0;
        rdy  <= 1'b0;
        hold <= '0;
      end else begin
        full <= full_nxt;
        rdy  <= ~full_nxt;
        if (push) hold <= in_data;
      end
    end
  end else begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign in_ready  = en & out_ready;
    assign out_valid = in_valid & in_ready;
    assign out_data  = in_data;
  end
endmodule

// File: rtl/control_escritura.sv
// Raster pixel writer into a frame buffer.
// Define CONTROL_ESCRITURA_SKID_EN to register in_ready through a skid buffer.
module control_escritura
  import imagen_pkg::*;
#(
  parameter logic [18:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wr_wait,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);
`ifdef CONTROL_ESCRITURA_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [20:0] TOTAL    = 21'(IMG_W * IMG_H);
  localparam logic [9:0]  COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0]  ROW_LAST = 10'(IMG_H - 1);
  localparam logic [18:0] ROW_STEP = 19'(STRIDE - IMG_W + 1);

  state_t      state;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [20:0] in_cnt;
  logic        all_in;
  logic        en;
  logic        dn_ready;
  logic        take;
  logic        last;
  logic        xfer;
  logic        load;
  logic        sb_valid;
  logic [7:0]  sb_data;

  // en depends only on flops, so in_ready gating adds no wr_wait path.
  assign en       = (state == WRITE) & ~all_in;
  assign dn_ready = ~wr_wait & ~(wr_en & wr_wait);
  assign take     = wr_en & ~wr_wait;
  assign last     = take & (col == COL_LAST) & (row == ROW_LAST);
  assign xfer     = in_valid & in_ready;
  assign load     = sb_valid & dn_ready;

  skid_buffer_8 #(
    .SKID(SKID)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (sb_data),
    .out_valid(sb_valid),
    .out_ready(dn_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= BASE_ADDR;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      col     <= '0;
      row     <= '0;
      in_cnt  <= '0;
      all_in  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= WRITE;
            busy    <= 1'b1;
            wr_addr <= BASE_ADDR;
            col     <= '0;
            row     <= '0;
            in_cnt  <= '0;
            all_in  <= 1'b0;
          end
        end
        WRITE: begin
          if (xfer) begin
            in_cnt <= in_cnt + 21'd1;
            if (in_cnt + 21'd1 == TOTAL) all_in <= 1'b1;
          end
          if (load) begin
            wr_en   <= 1'b1;
            wr_data <= sb_data;
          end else if (take) begin
            wr_en <= 1'b0;
          end
          if (take) begin
            if (col == COL_LAST) begin
              col     <= '0;
              row     <= (row == ROW_LAST) ? '0 : row + 10'd1;
              wr_addr <= wr_addr + ROW_STEP;
            end else begin
              col     <= col + 10'd1;
              wr_addr <= wr_addr + 19'd1;
            end
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
